// File: rtl/sat_accumulator.sv
// Block accumulator: sums LEN signed samples with per-step saturation, then holds the result for a valid/ready handshake.
// Optional ovf_cnt output (count of saturating samples) enabled by defining SAT_ACCUMULATOR_OVF_CNT_EN.
module sat_accumulator #(
  parameter int N   = 8,
  parameter int LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_data,
  input  logic                sub,
  input  logic                clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_data,
  output logic                out_sat
`ifdef SAT_ACCUMULATOR_OVF_CNT_EN
  ,
  output logic [7:0]          ovf_cnt
`endif
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic signed [N:0] SUM_MAX = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] SUM_MIN = {2'b11, {(N-1){1'b0}}};

  typedef enum logic {ACC, HOLD} state_t;

  state_t              state_q;
  logic signed [N-1:0] acc_q;
  logic [CW-1:0]       cnt_q;
  logic                flag_q;
  logic                out_valid_q;
  logic signed [N-1:0] out_data_q;
  logic                out_sat_q;

  logic signed [N:0]   acc_w;
  logic signed [N:0]   din_w;
  logic signed [N:0]   sum_d;
  logic signed [N-1:0] result_d;
  logic                stepsat_d;
  logic                accept;

  function automatic logic signed [N-1:0] saturate(input logic signed [N:0] s);
    if (s > SUM_MAX)      return SUM_MAX[N-1:0];
    else if (s < SUM_MIN) return SUM_MIN[N-1:0];
    else                  return s[N-1:0];
  endfunction

  function automatic logic overflows(input logic signed [N:0] s);
    return (s > SUM_MAX) || (s < SUM_MIN);
  endfunction

  assign in_ready  = (state_q == ACC) && !clr;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // One extra bit of headroom makes acc - (-2^(N-1)) exact before clamping.
  always_comb begin
    acc_w     = {acc_q[N-1], acc_q};
    din_w     = {in_data[N-1], in_data};
    sum_d     = sub ? (acc_w - din_w) : (acc_w + din_w);
    result_d  = saturate(sum_d);
    stepsat_d = overflows(sum_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (clr) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
          end else if (accept) begin
            if (cnt_q == LAST) begin
              out_data_q  <= result_d;
              out_sat_q   <= flag_q | stepsat_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              flag_q      <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q  <= result_d;
              cnt_q  <= cnt_q + CW'(1);
              flag_q <= flag_q | stepsat_d;
            end
          end
        end
        HOLD: begin
          // clr is deliberately ignored here so a finished result is never dropped.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

`ifdef SAT_ACCUMULATOR_OVF_CNT_EN
  logic [7:0] ovf_q;
  assign ovf_cnt = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 8'd0;
    end else if (accept && stepsat_d && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sat_accumulator.sv
// Self-checking bench for sat_accumulator: directed scenarios plus random traffic against an integer reference model.
module tb_sat_accumulator;
  localparam int N   = 8;
  localparam int LEN = 4;
  localparam int MAXV = 2 ** (N - 1) - 1;
  localparam int MINV = -(2 ** (N - 1));

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [N-1:0] in_data = '0;
  logic                sub = 1'b0;
  logic                clr = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [N-1:0] out_data;
  logic                out_sat;
`ifdef SAT_ACCUMULATOR_OVF_CNT_EN
  logic [7:0]          ovf_cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state (plain integers)
  int m_hold, m_acc, m_cnt, m_flag, m_ov, m_od, m_os, m_ovf;

  sat_accumulator #(.N(N), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sub(sub), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
`ifdef SAT_ACCUMULATOR_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_acc = 0; m_cnt = 0; m_flag = 0;
    m_ov = 0; m_od = 0; m_os = 0; m_ovf = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model, cross the edge.
  task automatic cyc(input logic v, input int d, input logic s, input logic c, input logic r, input logic o);
    int sum, res, ss;
    in_valid = v; in_data = d[N-1:0]; sub = s; clr = c; rst = r; out_ready = o;
    @(negedge clk);
    check_eq("in_ready", in_ready, (m_hold == 0 && !c) ? 1 : 0);
    check_eq("out_valid", out_valid, m_ov);
    check_eq("out_data", out_data, m_od);
    check_eq("out_sat", out_sat, m_os);
`ifdef SAT_ACCUMULATOR_OVF_CNT_EN
    check_eq("ovf_cnt", ovf_cnt, m_ovf);
`endif
    if (r) begin
      model_reset();
    end else if (m_hold == 0) begin
      if (c) begin
        m_acc = 0; m_cnt = 0; m_flag = 0;
      end else if (v) begin
        sum = s ? (m_acc - d) : (m_acc + d);
        ss  = (sum > MAXV || sum < MINV) ? 1 : 0;
        res = (sum > MAXV) ? MAXV : ((sum < MINV) ? MINV : sum);
        if (ss != 0 && m_ovf < 255) m_ovf++;
        if (m_cnt == LEN - 1) begin
          m_od = res; m_os = m_flag | ss; m_ov = 1;
          m_acc = 0; m_cnt = 0; m_flag = 0; m_hold = 1;
        end else begin
          m_acc = res; m_cnt++; m_flag = m_flag | ss;
        end
      end
    end else if (o) begin
      m_ov = 0; m_hold = 0;
    end
    @(posedge clk); #1;
  endtask

  // Present a sample once the model says the block is accepting; drain any pending result meanwhile.
  task automatic send(input int d, input logic s);
    int tries = 0;
    while (m_hold != 0 && tries < 8) begin
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      tries++;
    end
    if (m_hold != 0) check_eq("send_timeout", 1, 0);
    else cyc(1'b1, d, s, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Scenario 1: reset with in_valid high
    in_valid = 1'b1; in_data = 8'sd55; rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    cyc(1'b1, 55, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_sat", out_sat, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Scenario 2: plain sum, result one cycle after last sample
    send(10, 0); send(20, 0); send(30, 0);
    check_eq("s2_pre_valid", out_valid, 0);
    send(40, 0);
    check_eq("s2_valid", out_valid, 1);
    check_eq("s2_data", out_data, 100);
    check_eq("s2_sat", out_sat, 0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("s2_valid_fall", out_valid, 0);

    // Scenario 3: saturation mid-block and at negative rail
    send(100, 0); send(100, 0); send(-50, 0); send(1, 0);
    check_eq("s3a_data", out_data, 78);
    check_eq("s3a_sat", out_sat, 1);
    send(-100, 0); send(-100, 0); send(-100, 0); send(0, 0);
    check_eq("s3b_data", out_data, -128);
    check_eq("s3b_sat", out_sat, 1);

    // Scenario 4: subtract
    send(-128, 1); send(0, 0); send(0, 0); send(0, 0);
    check_eq("s4a_data", out_data, 127);
    check_eq("s4a_sat", out_sat, 1);
    send(5, 1); send(5, 1); send(5, 1); send(5, 1);
    check_eq("s4b_data", out_data, -20);
    check_eq("s4b_sat", out_sat, 0);

    // Scenario 5: backpressure
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("s5_hold_valid", out_valid, 1);
      check_eq("s5_hold_data", out_data, 10);
      check_eq("s5_hold_ready", in_ready, 0);
    end
    cyc(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("s5_valid_drop", out_valid, 0);
    check_eq("s5_ready_rise", in_ready, 1);

    // Scenario 6: abort with clr, then with rst
    send(5, 0); send(5, 0);
    cyc(1'b1, 99, 1'b0, 1'b1, 1'b0, 1'b1);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    check_eq("s6a_data", out_data, 10);
    check_eq("s6a_sat", out_sat, 0);
    send(5, 0); send(5, 0);
    cyc(1'b1, 99, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("s6b_rst_valid", out_valid, 0);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    check_eq("s6b_data", out_data, 10);
    check_eq("s6b_sat", out_sat, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 255)) - 128,
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
